// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, CON bit positions,
// FSM state types and the baud counter width helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package uart_pkg;

    // Register byte offsets from BASE_ADDR.
    localparam logic [31:0] TXD_OFS = 32'h0000_0000;
    localparam logic [31:0] RXD_OFS = 32'h0000_0004;
    localparam logic [31:0] CON_OFS = 32'h0000_0008;

    // CON register bit positions.
    localparam int CON_TX_IRQ_EN = 0;
    localparam int CON_RX_IRQ_EN = 1;
    localparam int CON_RX_VALID  = 2;
    localparam int CON_TX_BUSY   = 3;
    localparam int CON_TX_DONE   = 4;
    localparam int CON_RX_OVR    = 5;
    localparam int CON_FERR      = 6;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Bits needed for a counter running 0 .. div-1.
    function automatic int cnt_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, start-bit glitch filter, mid-bit sampling FSM.
// Latency: rx_done/rx_ferr pulse ~2 + 9.5*BAUD_DIV cycles after the start-bit falling edge.
// Backpressure: none; the caller must latch rx_byte on the one-cycle rx_done strobe.
// Ports: clk, reset (async active-low), rx (async serial in),
//        rx_byte (received data, valid with rx_done), rx_done (good frame), rx_ferr (bad stop bit).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_done,
    output logic       rx_ferr
);

    localparam int CW = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    logic            rx_meta_q;
    logic            rx_sync_q;
    logic            rx_prev_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    // Synchronizer resets to the idle line level so reset release is not seen as a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: a line that has returned high was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // shift_q is stable for the whole stop bit, so it is valid alongside done_q.
    assign rx_byte = shift_q;
    assign rx_done = done_q;
    assign rx_ferr = ferr_q;

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART slave: TXD/RXD/CON registers, TX FSM, level interrupt.
// Latency: rdata combinational with rd; tx goes low at the TXD write edge; irqout follows state by one edge.
// Backpressure: none; a TXD write while busy is dropped, a second received byte overwrites (rx_overrun).
// Ports: clk, reset (async active-low), rd/wr/addr/wdata (CPU bus), rdata (zero unless a register is read),
//        rx (serial in), tx (serial out, idle high), irqout (interrupt request).
module uart_peripheral
    import uart_pkg::*;
#(
    parameter int          BAUD_DIV  = 5208,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irqout
);

    localparam int CW = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    // ---------------- bus decode ----------------
    logic hit_txd, hit_rxd, hit_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign hit_txd = (addr == BASE_ADDR + TXD_OFS);
    assign hit_rxd = (addr == BASE_ADDR + RXD_OFS);
    assign hit_con = (addr == BASE_ADDR + CON_OFS);

    assign wr_txd = wr && hit_txd;
    assign wr_con = wr && hit_con;
    assign rd_rxd = rd && hit_rxd;
    assign rd_con = rd && hit_con;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    // ---------------- register state ----------------
    logic       tx_irq_en_q;
    logic       rx_irq_en_q;
    logic       rx_valid_q;
    logic       tx_done_q;
    logic       rx_ovr_q;
    logic       ferr_q;
    logic [7:0] rx_byte_q;

    // ---------------- TX FSM ----------------
    tx_state_e      tx_state_q, tx_state_d;
    logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]     tx_idx_q, tx_idx_d;
    logic [7:0]     tx_shift_q, tx_shift_d;
    logic           tx_q, tx_d;
    logic           tx_busy;
    logic           tx_done_set;

    assign tx_busy = (tx_state_q != TX_IDLE);

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_shift_d  = tx_shift_q;
        tx_done_set = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_idx_d = '0;
                if (wr_txd) begin
                    tx_state_d = TX_START;
                    tx_shift_d = wdata[7:0];
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    tx_idx_d = tx_idx_q + 3'd1;
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_state_d  = TX_IDLE;
                    tx_done_set = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Line level derived from the next state so tx is a clean flop output.
    always_comb begin
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[tx_idx_d];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

    // ---------------- RX path ----------------
    logic [7:0] rx_core_byte;
    logic       rx_done;
    logic       rx_ferr;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx_core (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_byte (rx_core_byte),
        .rx_done (rx_done),
        .rx_ferr (rx_ferr)
    );

    // ---------------- CON / RXD registers ----------------
    // Set conditions are tested before read-clears so a same-edge event is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_irq_en_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_ovr_q    <= 1'b0;
            ferr_q      <= 1'b0;
            rx_byte_q   <= '0;
        end else begin
            if (wr_con) begin
                tx_irq_en_q <= wdata[CON_TX_IRQ_EN];
                rx_irq_en_q <= wdata[CON_RX_IRQ_EN];
            end

            if (rx_done) begin
                rx_byte_q  <= rx_core_byte;
                rx_valid_q <= 1'b1;
            end else if (rd_rxd) begin
                rx_valid_q <= 1'b0;
            end

            // An RXD read at the completing edge consumed the old byte, so no overrun.
            if (rx_done && rx_valid_q && !rd_rxd) begin
                rx_ovr_q <= 1'b1;
            end else if (rd_con) begin
                rx_ovr_q <= 1'b0;
            end

            if (tx_done_set) begin
                tx_done_q <= 1'b1;
            end else if (rd_con) begin
                tx_done_q <= 1'b0;
            end

            if (rx_ferr) begin
                ferr_q <= 1'b1;
            end else if (rd_con) begin
                ferr_q <= 1'b0;
            end
        end
    end

    // ---------------- read mux ----------------
    logic [31:0] con_word;

    always_comb begin
        con_word                = '0;
        con_word[CON_TX_IRQ_EN] = tx_irq_en_q;
        con_word[CON_RX_IRQ_EN] = rx_irq_en_q;
        con_word[CON_RX_VALID]  = rx_valid_q;
        con_word[CON_TX_BUSY]   = tx_busy;
        con_word[CON_TX_DONE]   = tx_done_q;
        con_word[CON_RX_OVR]    = rx_ovr_q;
        con_word[CON_FERR]      = ferr_q;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (hit_rxd) begin
                rdata = {24'b0, rx_byte_q};
            end else if (hit_con) begin
                rdata = con_word;
            end
        end
    end

    // Built only from flops: no combinational path from the bus to the interrupt.
    assign irqout = (tx_irq_en_q && tx_done_q) || (rx_irq_en_q && rx_valid_q);

endmodule

// File: tb/tb_uart_peripheral.sv
module tb_uart_peripheral;

    localparam int          B    = 8;
    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] A_TXD = BASE;
    localparam logic [31:0] A_RXD = BASE + 32'd4;
    localparam logic [31:0] A_CON = BASE + 32'd8;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rx    = 1'b1;
    logic        tx;
    logic        irqout;

    always #5 clk = ~clk;

    uart_peripheral #(
        .BAUD_DIV  (B),
        .BASE_ADDR (BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rx     (rx),
        .tx     (tx),
        .irqout (irqout)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int wr_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // One-cycle store; wr_cyc records the index of the committing clock edge.
    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
        wr_cyc = cyc;
    endtask

    // One-cycle load; rdata is sampled in the same cycle as rd.
    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1; addr = a;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Drive one 8N1 frame on rx followed by one idle bit time.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk); rx = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge clk);
        end
        rx = stop;
        repeat (B) @(negedge clk);
        rx = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    // Serial monitor: decodes frames on tx by sampling mid-bit. Bit 8 flags a bad start/stop.
    logic [8:0] tx_got[$];
    bit         mon_en = 1'b0;
    logic [7:0] mon_b;
    logic       mon_ok;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && reset && tx == 1'b0) begin
                repeat (B / 2) @(negedge clk);
                mon_ok = (tx == 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    mon_b[i] = tx;
                end
                repeat (B) @(negedge clk);
                mon_ok = mon_ok && (tx == 1'b1);
                if (mon_en) tx_got.push_back({~mon_ok, mon_b});
            end
        end
    end

    typedef struct packed {
        logic [1:0]  op;    // 0 read, 1 write, 2 rdata with rd low
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] d;
        logic [7:0]  v;
        logic [7:0]  tx_exp[$];
        int          wave_err;
        int          last_acc;
        int          low_cnt;
        logic        mv, mo, mf;
        logic [7:0]  mb;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irqout", 32'(irqout), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b1;

        // ---------------- register access table ----------------
        vecs[0]  = '{2'd0, A_CON,          32'h0,          32'h00};
        vecs[1]  = '{2'd0, A_RXD,          32'h0,          32'h00};
        vecs[2]  = '{2'd0, A_TXD,          32'h0,          32'h00};
        vecs[3]  = '{2'd0, BASE + 32'd12,  32'h0,          32'h00};
        vecs[4]  = '{2'd1, A_CON,          32'hFFFF_FFFF,  32'h00};
        vecs[5]  = '{2'd0, A_CON,          32'h0,          32'h03};
        vecs[6]  = '{2'd2, A_CON,          32'h0,          32'h00};
        vecs[7]  = '{2'd1, BASE + 32'd12,  32'h0000_00FF,  32'h00};
        vecs[8]  = '{2'd0, BASE - 32'd4,   32'h0,          32'h00};
        vecs[9]  = '{2'd1, A_CON,          32'h0000_0002,  32'h00};
        vecs[10] = '{2'd0, A_CON,          32'h0,          32'h02};
        vecs[11] = '{2'd1, A_RXD,          32'h0000_00FF,  32'h00};
        vecs[12] = '{2'd0, A_RXD,          32'h0,          32'h00};
        vecs[13] = '{2'd1, A_CON,          32'h0,          32'h00};
        vecs[14] = '{2'd0, A_CON,          32'h0,          32'h00};

        for (int i = 0; i < 15; i++) begin
            case (vecs[i].op)
                2'd0: begin
                    bus_rd(vecs[i].a, d);
                    check($sformatf("vec%0d_rd", i), d, vecs[i].exp);
                end
                2'd1: bus_wr(vecs[i].a, vecs[i].wd);
                default: begin
                    @(negedge clk);
                    rd = 1'b0; addr = vecs[i].a;
                    #1 check($sformatf("vec%0d_idle", i), rdata, vecs[i].exp);
                end
            endcase
        end

        // ---------------- TX 0xA5 waveform and interrupt ----------------
        bus_wr(A_CON, 32'h1);
        tx_got.delete();
        mon_en = 1'b1;
        v = 8'hA5;
        bus_wr(A_TXD, 32'h0000_00A5);
        wave_err = 0;
        for (int k = 0; k < 10 * B; k++) begin
            if (k / B == 0) begin
                if (tx !== 1'b0) wave_err++;
            end else if (k / B == 9) begin
                if (tx !== 1'b1) wave_err++;
            end else begin
                if (tx !== v[k / B - 1]) wave_err++;
            end
            if (k == 10 * B - 1) check("irq_before_stop_end", 32'(irqout), 32'd0);
            @(negedge clk);
        end
        check("tx_a5_wave_errs", 32'(wave_err), 32'd0);
        check("tx_done_irq", 32'(irqout), 32'd1);
        check("tx_idle_high", 32'(tx), 32'd1);
        check("tx_mon_count", 32'(tx_got.size()), 32'd1);
        if (tx_got.size() > 0) check("tx_mon_a5", 32'(tx_got[0]), 32'h0A5);
        bus_rd(A_CON, d);
        check("con_tx_done", d, 32'h11);
        bus_rd(A_CON, d);
        check("con_tx_done_cleared", d, 32'h01);
        check("irq_cleared", 32'(irqout), 32'd0);

        // ---------------- RX 0x3C ----------------
        bus_wr(A_CON, 32'h0);
        send_rx(8'h3C, 1'b1);
        bus_rd(A_CON, d);  check("rx3c_con", d, 32'h04);
        bus_rd(A_RXD, d);  check("rx3c_rxd1", d, 32'h3C);
        bus_rd(A_RXD, d);  check("rx3c_rxd2", d, 32'h3C);
        bus_rd(A_CON, d);  check("rx3c_con_after", d, 32'h00);

        // ---------------- overrun ----------------
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_rd(A_CON, d);  check("ovr_con", d, 32'h24);
        bus_rd(A_CON, d);  check("ovr_con_cleared", d, 32'h04);
        bus_rd(A_RXD, d);  check("ovr_rxd", d, 32'h22);
        bus_rd(A_CON, d);  check("ovr_con_final", d, 32'h00);

        // ---------------- frame error and glitch ----------------
        send_rx(8'h5A, 1'b0);
        bus_rd(A_CON, d);  check("ferr_con", d, 32'h40);
        bus_rd(A_CON, d);  check("ferr_con_cleared", d, 32'h00);
        @(negedge clk); rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (4 * B) @(negedge clk);
        bus_rd(A_CON, d);  check("glitch_con", d, 32'h00);
        bus_rd(A_RXD, d);  check("ferr_byte_discarded", d, 32'h22);

        // ---------------- TXD write while busy ----------------
        tx_got.delete();
        bus_wr(A_TXD, 32'h55);
        bus_rd(A_CON, d);  check("busy_con", d, 32'h08);
        repeat (16) @(negedge clk);
        bus_wr(A_TXD, 32'hFF);
        repeat (12 * B) @(negedge clk);
        check("busy_drop_count", 32'(tx_got.size()), 32'd1);
        if (tx_got.size() > 0) check("busy_drop_byte", 32'(tx_got[0]), 32'h055);
        bus_rd(BASE + 32'd12, d);
        check("unmapped_rd", d, 32'h0);

        // ---------------- reset mid-frame ----------------
        bus_wr(A_CON, 32'h1);
        check("pre_rst_irq", 32'(irqout), 32'd1);
        mon_en = 1'b0;
        bus_wr(A_TXD, 32'hF0);
        repeat (29) @(negedge clk);
        check("pre_rst_tx_low", 32'(tx), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_async_tx", 32'(tx), 32'd1);
        check("rst_async_irq", 32'(irqout), 32'd0);
        @(negedge clk); reset = 1'b1;
        bus_rd(A_CON, d);  check("rst_con", d, 32'h0);
        low_cnt = 0;
        for (int k = 0; k < 12 * B; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
        end
        check("rst_frame_aborted", 32'(low_cnt), 32'd0);

        // ---------------- randomized TX against a timing model ----------------
        tx_got.delete();
        tx_exp.delete();
        mon_en = 1'b1;
        last_acc = -1000;
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom);
            bus_wr(A_TXD, {24'h0, v});
            // The transmitter is busy for the 10*B edges following an accepted write.
            if (wr_cyc > last_acc + 10 * B) begin
                tx_exp.push_back(v);
                last_acc = wr_cyc;
            end
            repeat ($urandom_range(5, 110)) @(negedge clk);
        end
        repeat (12 * B) @(negedge clk);
        mon_en = 1'b0;
        check("rand_tx_count", 32'(tx_got.size()), 32'(tx_exp.size()));
        for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++) begin
            check($sformatf("rand_tx_byte%0d", i), 32'(tx_got[i]), {24'h0, tx_exp[i]});
        end

        // ---------------- randomized RX against a register model ----------------
        bus_rd(A_CON, d);
        bus_wr(A_CON, 32'h2);
        mv = 1'b0; mo = 1'b0; mf = 1'b0; mb = 8'h22;
        for (int i = 0; i < 14; i++) begin
            v = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    send_rx(v, 1'b1);
                    if (mv) mo = 1'b1;
                    mb = v; mv = 1'b1;
                end
                1: begin
                    send_rx(v, 1'b0);
                    mf = 1'b1;
                end
                2: begin
                    bus_rd(A_RXD, d);
                    check($sformatf("rand_rxd%0d", i), d, {24'h0, mb});
                    mv = 1'b0;
                end
                default: begin
                    bus_rd(A_CON, d);
                    check($sformatf("rand_con%0d", i), d,
                          {25'h0, mf, mo, 1'b0, 1'b0, mv, 1'b1, 1'b0});
                    mo = 1'b0; mf = 1'b0;
                end
            endcase
            check($sformatf("rand_irq%0d", i), 32'(irqout), 32'(mv));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_peripheral.md
# uart_peripheral

Memory-mapped UART responder on the CPU's data bus, the slave side of the load/store interface the CPU drives with `rd`, `wr`, `addr` and `wdata`. It transmits and receives 8N1 serial frames, holds one byte in each direction, and raises an interrupt request when a byte arrives or a transmission completes. It sits beside the data memory and the existing peripheral block. Its `rdata` is zero when the block is not addressed, so the top level can OR it into the load data path.

## Interface
Parameters:
- `BAUD_DIV`, default 5208. Clock cycles per serial bit (50 MHz / 9600).
- `BASE_ADDR`, default 32'h4000_0018. Byte address of the first register.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  reset; asynchronous, active-low.
- `rd`  input  1  load strobe from the CPU, one cycle per load.
- `wr`  input  1  store strobe from the CPU, one cycle per store.
- `addr`  input  32  byte address (ALU output).
- `wdata`  input  32  store data.
- `rdata`  output  32  load data. Combinational. Zero unless `rd` is high and `addr` hits a register.
- `rx`  input  1  serial input, asynchronous to `clk`.
- `tx`  output  1  serial output. Idle high.
- `irqout`  output  1  level interrupt request to the control unit.

## Operation
- Registers, word-aligned from `BASE_ADDR`:
  - +0 TXD: write-only. `wdata[7:0]` is the byte to send.
  - +4 RXD: read-only. `{24'b0, rx_byte}`.
  - +8 CON: read/write control and status.
- CON bits:
  - [0] tx_irq_en, R/W.
  - [1] rx_irq_en, R/W.
  - [2] rx_valid, RO.
  - [3] tx_busy, RO.
  - [4] tx_done, RO, sticky.
  - [5] rx_overrun, RO, sticky.
  - [6] frame_err, RO, sticky.
  - Other bits read 0.
- CON write: loads only bits [1:0].
- CON read: returns the current value, then clears bits [6:4] at the same clock edge.
- TXD write while tx_busy: the byte is dropped. No state changes.
- RXD read: returns rx_byte and clears rx_valid at that edge.
- Addresses outside the three registers: writes are ignored and reads return 0.
- `irqout` = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid).
- TX FSM, states IDLE → START → DATA → STOP → IDLE:
  - Each state lasts BAUD_DIV cycles.
  - DATA sends 8 bits, LSB first, counted by a 3-bit index.
  - Entering IDLE from STOP sets tx_done.
- RX path: `rx` passes through a 2-flop synchronizer. RX FSM states:
  - IDLE: a synchronized falling edge moves to START.
  - START: at BAUD_DIV/2 cycles, if the line is still low go to DATA; otherwise return to IDLE (glitch rejected).
  - DATA: sample every BAUD_DIV cycles, 8 bits, LSB first.
  - STOP: sample after BAUD_DIV cycles.
    - Stop bit = 1: load rx_byte and set rx_valid. If rx_valid was already set, also set rx_overrun; the new byte replaces the old one.
    - Stop bit = 0: set frame_err and discard the byte.
    - Either way, return to IDLE.
- Simultaneous events at the same edge:
  - RXD read and a new byte completing: the new byte wins; rx_valid stays 1 and rx_overrun is not set.
  - CON read and a sticky bit being set: the set wins.

## Timing
- Reset values:
  - `tx` = 1, `irqout` = 0, `rdata` = 0.
  - All CON bits = 0, rx_byte = 0.
  - Both FSMs in IDLE, all counters 0.
- Reset asserted mid-frame: both FSMs abort immediately and `tx` returns high asynchronously.
- TX latency: for a TXD write at edge N, tx_busy = 1 and `tx` = 0 from edge N. The stop bit ends at edge N + 10·BAUD_DIV, where tx_busy falls and tx_done rises.
- RX latency: rx_valid rises about 2 + 9.5·BAUD_DIV cycles after the falling edge of the start bit on `rx`.
- `rdata` is combinational in the same cycle as `rd`, so a single-cycle load works. All side effects occur at the end of that cycle.
- `irqout` is registered-state derived: it changes one edge after its cause and carries no combinational path from the bus.

## Structure
- Package `uart_pkg`:
  - Register offsets TXD_OFS = 0, RXD_OFS = 4, CON_OFS = 8.
  - CON bit indices.
  - Enum types for the TX and RX FSM states.
- Sub-module `uart_rx_core`: synchronizer, RX FSM and baud counter. Outputs a byte with a one-cycle `rx_done` strobe and a `rx_ferr` strobe.
- The TX FSM, register file and bus decode stay in the top module.

## Test plan
All scenarios use BAUD_DIV = 8.
- Reset, then write TXD = 0xA5 → `tx` shows 0, then bits 1,0,1,0,0,1,0,1, then 1, each held 8 cycles. tx_busy is 1 for 80 cycles. tx_done = 1 after. With tx_irq_en set, `irqout` = 1.
- Drive frame 0x3C on `rx` → CON reads 0x04 and RXD reads 0x3C. A second RXD read returns 0x3C with rx_valid = 0.
- Send two frames (0x11, 0x22) with no RXD read between → RXD = 0x22, rx_overrun = 1. A CON read clears bit 5.
- Frame whose stop bit = 0 → frame_err = 1, rx_valid = 0. A 3-cycle low glitch on idle `rx` → no state change.
- Write TXD = 0x55 and, 20 cycles later, TXD = 0xFF → only 0x55 is transmitted. Read of `BASE_ADDR`+12 → `rdata` = 0.
- Assert `reset` at cycle 30 of a TX frame → `tx` = 1 immediately, all CON bits = 0, `irqout` = 0.
